// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP memory-access / write-back stage:
// default widths, mem_mode encodings, load FSM state encodings and
// the mem_mode decoder that folds reserved codes onto NONE.
package dsp_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_RADDR_W = 5;

    typedef enum logic [2:0] {
        MEM_NONE  = 3'd0,
        MEM_LD_B1 = 3'd1,
        MEM_LD_B2 = 3'd2,
        MEM_ST_B2 = 3'd3
    } mem_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_LOAD_WB   = 2'd2
    } ld_state_e;

    // Codes 4..7 are reserved and execute as a plain NONE operation.
    function automatic mem_mode_e decode_mode(input logic [2:0] mode);
        case (mode)
            3'd1:    return MEM_LD_B1;
            3'd2:    return MEM_LD_B2;
            3'd3:    return MEM_ST_B2;
            default: return MEM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dsp_load_ctrl.sv
// Load sequencer: tracks an outstanding data-memory read, times the
// read latency with a down-counter and flags the cycle whose closing
// edge must capture read data.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | no load in flight, stage accepts operations
// ST_LOAD_WAIT | read address on the bank, waiting MEM_LAT cycles
// ST_LOAD_WB   | captured data is on the register-file write port
module dsp_load_ctrl
    import dsp_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic sample,
    output logic in_ready
);

    // Counter is loaded with MEM_LAT-1 so terminal count (0) lands on
    // the MEM_LAT-th wait cycle.
    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    ld_state_e  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            ST_LOAD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = ST_LOAD_WB;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_LOAD_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sample   = (state_q == ST_LOAD_WAIT) && (cnt_q == 2'd0);
    assign in_ready = (state_q == ST_IDLE);

endmodule

// File: rtl/dsp_mem_wb.sv
// Memory-access and write-back stage of the DSP core. Loads from data
// bank I or II, stores to bank II, drives the register-file write port
// and stalls fetch/decode while a load is outstanding.
// Optional build macro DSP_MEM_ERR_EN adds sticky err_flag / err_mode
// outputs that record acceptance of a reserved mem_mode.
module dsp_mem_wb
    import dsp_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int RADDR_W = DEF_RADDR_W,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  store_data,
    input  logic [2:0]         mem_mode,
    input  logic               wb_en_in,
    input  logic [RADDR_W-1:0] reg_dest_in,
    output logic [ADDR_W-1:0]  read_addr_1,
    input  logic [DATA_W-1:0]  read_data_1,
    output logic [ADDR_W-1:0]  read_addr_2,
    input  logic [DATA_W-1:0]  read_data_2,
    output logic [ADDR_W-1:0]  write_addr_2,
    output logic [DATA_W-1:0]  write_data_2,
    output logic               write_en_2,
    output logic [RADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0]  rf_write_data,
    output logic               rf_write_en,
`ifdef DSP_MEM_ERR_EN
    output logic               err_flag,
    output logic [2:0]         err_mode,
`endif
    output logic               stall
);

    mem_mode_e mode;
    logic      accept;
    logic      sample;
    logic      is_load;
    logic      wb_ok;

    logic [ADDR_W-1:0]  read_addr_1_q, read_addr_1_d;
    logic [ADDR_W-1:0]  read_addr_2_q, read_addr_2_d;
    logic [ADDR_W-1:0]  write_addr_2_q, write_addr_2_d;
    logic [DATA_W-1:0]  write_data_2_q, write_data_2_d;
    logic               write_en_2_q, write_en_2_d;
    logic [RADDR_W-1:0] rf_write_addr_q, rf_write_addr_d;
    logic [DATA_W-1:0]  rf_write_data_q, rf_write_data_d;
    logic               rf_write_en_q, rf_write_en_d;
    logic               ld_bank2_q, ld_bank2_d;
    logic               ld_wb_q, ld_wb_d;
    logic [RADDR_W-1:0] ld_dest_q, ld_dest_d;

    assign mode    = decode_mode(mem_mode);
    assign accept  = in_valid && in_ready;
    assign is_load = (mode == MEM_LD_B1) || (mode == MEM_LD_B2);
    // Register 0 is hardwired zero, so a write to it is dropped here.
    assign wb_ok   = wb_en_in && (reg_dest_in != '0);

    dsp_load_ctrl #(
        .MEM_LAT (MEM_LAT)
    ) u_load_ctrl (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && is_load),
        .sample   (sample),
        .in_ready (in_ready)
    );

    // Next values for the memory-side and register-file-side outputs.
    always_comb begin
        read_addr_1_d   = read_addr_1_q;
        read_addr_2_d   = read_addr_2_q;
        write_addr_2_d  = write_addr_2_q;
        write_data_2_d  = write_data_2_q;
        write_en_2_d    = 1'b0;
        rf_write_addr_d = rf_write_addr_q;
        rf_write_data_d = rf_write_data_q;
        rf_write_en_d   = 1'b0;
        ld_bank2_d      = ld_bank2_q;
        ld_wb_d         = ld_wb_q;
        ld_dest_d       = ld_dest_q;

        if (accept) begin
            read_addr_1_d = (mode == MEM_LD_B1) ? ADDR_W'(alu_result) : '0;
            read_addr_2_d = (mode == MEM_LD_B2) ? ADDR_W'(alu_result) : '0;
            case (mode)
                MEM_ST_B2: begin
                    write_en_2_d   = 1'b1;
                    write_addr_2_d = ADDR_W'(alu_result);
                    write_data_2_d = store_data;
                end
                MEM_LD_B1, MEM_LD_B2: begin
                    ld_bank2_d = (mode == MEM_LD_B2);
                    ld_wb_d    = wb_ok;
                    ld_dest_d  = reg_dest_in;
                end
                default: begin
                    rf_write_en_d   = wb_ok;
                    rf_write_addr_d = reg_dest_in;
                    rf_write_data_d = alu_result;
                end
            endcase
        end

        // Only reachable in LOAD_WAIT, so never collides with an accept.
        if (sample) begin
            rf_write_en_d   = ld_wb_q;
            rf_write_addr_d = ld_dest_q;
            rf_write_data_d = ld_bank2_q ? read_data_2 : read_data_1;
        end
    end

    // Output and load-context registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_addr_1_q   <= '0;
            read_addr_2_q   <= '0;
            write_addr_2_q  <= '0;
            write_data_2_q  <= '0;
            write_en_2_q    <= 1'b0;
            rf_write_addr_q <= '0;
            rf_write_data_q <= '0;
            rf_write_en_q   <= 1'b0;
            ld_bank2_q      <= 1'b0;
            ld_wb_q         <= 1'b0;
            ld_dest_q       <= '0;
        end else begin
            read_addr_1_q   <= read_addr_1_d;
            read_addr_2_q   <= read_addr_2_d;
            write_addr_2_q  <= write_addr_2_d;
            write_data_2_q  <= write_data_2_d;
            write_en_2_q    <= write_en_2_d;
            rf_write_addr_q <= rf_write_addr_d;
            rf_write_data_q <= rf_write_data_d;
            rf_write_en_q   <= rf_write_en_d;
            ld_bank2_q      <= ld_bank2_d;
            ld_wb_q         <= ld_wb_d;
            ld_dest_q       <= ld_dest_d;
        end
    end

`ifdef DSP_MEM_ERR_EN
    logic       err_flag_q, err_flag_d;
    logic [2:0] err_mode_q, err_mode_d;

    // Sticky record of the most recent accepted reserved mem_mode.
    always_comb begin
        err_flag_d = err_flag_q;
        err_mode_d = err_mode_q;
        if (accept && mem_mode[2]) begin
            err_flag_d = 1'b1;
            err_mode_d = mem_mode;
        end
    end

    // Error registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_flag_q <= 1'b0;
            err_mode_q <= 3'd0;
        end else begin
            err_flag_q <= err_flag_d;
            err_mode_q <= err_mode_d;
        end
    end

    assign err_flag = err_flag_q;
    assign err_mode = err_mode_q;
`endif

    assign read_addr_1   = read_addr_1_q;
    assign read_addr_2   = read_addr_2_q;
    assign write_addr_2  = write_addr_2_q;
    assign write_data_2  = write_data_2_q;
    assign write_en_2    = write_en_2_q;
    assign rf_write_addr = rf_write_addr_q;
    assign rf_write_data = rf_write_data_q;
    assign rf_write_en   = rf_write_en_q;
    assign stall         = ~in_ready;

endmodule
